// File: rtl/servo_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the
// APB servo PWM block.
package servo_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PULSE  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_FRAME  = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_DONE_BIT = 0;

    localparam int PULSE_W = 18;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } servo_state_e;

    // Clamp a raw bus value into [lo, hi]; the compare uses all 32 bits so large
    // writes saturate high instead of wrapping into range.
    function automatic logic [PULSE_W-1:0] sat_pulse(input logic [31:0] v,
                                                     input logic [31:0] lo,
                                                     input logic [31:0] hi);
        logic [31:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r[PULSE_W-1:0];
    endfunction

endpackage

// File: rtl/servo_pwm_core.sv
// Frame counter, shadow pulse register and comparator; produces the registered
// servo pulse and a one-cycle wrap strobe for the DONE flag.
module servo_pwm_core
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = 200000,
    parameter int NEUTRAL_PULSE = 15000,
    localparam int CW = $clog2(PERIOD_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [PULSE_W-1:0] pulse_i,
    output logic               pwm_o,
    output logic               wrap_o,
    output logic [CW-1:0]      count_o,
    output servo_state_e       state_o
);

    servo_state_e        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PULSE_W-1:0]  shadow_q, shadow_d;
    logic                pwm_q, pwm_d;
    logic [PULSE_W-1:0]  shadow_eff;
    logic                wrap;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pwm_d      = 1'b0;
        wrap       = 1'b0;
        // The pulse value is captured at count 0 so mid-frame writes wait a frame.
        shadow_eff = (cnt_q == '0) ? pulse_i : shadow_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    shadow_d = shadow_eff;
                    pwm_d    = (32'(cnt_q) < 32'(shadow_eff));
                    if (cnt_q == CW'(PERIOD_CYCLES - 1)) begin
                        cnt_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= PULSE_W'(NEUTRAL_PULSE);
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign wrap_o  = wrap;
    assign count_o = cnt_q;
    assign state_o = state_q;

endmodule

// File: rtl/servo_pwm_apb.sv
// APB3 slave wrapping the servo PWM core: CTRL/PULSE/STATUS/FRAME registers,
// zero-wait-state access and a level interrupt from STATUS.DONE.
module servo_pwm_apb
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = 200000,
    parameter int MIN_PULSE     = 10000,
    parameter int MAX_PULSE     = 20000,
    parameter int NEUTRAL_PULSE = 15000
) (
    input  logic        SYSCLK,
    input  logic        SYSRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        SERVO_PWM,
    output logic        SERVO_INT
);

    localparam int CW = $clog2(PERIOD_CYCLES);

    logic               en_q, en_d;
    logic               ie_q, ie_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               done_q, done_d;

    logic               mapped;
    logic [1:0]         reg_sel;
    logic               wr_en;
    logic               rd_en;
    logic               done_clr;
    logic               core_wrap;
    logic [CW-1:0]      core_count;
    servo_state_e       core_state;

    // Only the four word offsets at 0x00..0x0C respond; anything else is unmapped.
    assign mapped   = (PADDR[7:4] == 4'h0) && (PADDR[1:0] == 2'b00);
    assign reg_sel  = PADDR[3:2];
    assign wr_en    = PSEL && PENABLE && PWRITE && mapped;
    assign rd_en    = PSEL && !PWRITE && mapped;
    assign done_clr = wr_en && (reg_sel == REG_STATUS) && PWDATA[STATUS_DONE_BIT];

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        pulse_d = pulse_q;
        // A frame completion wins over a clear landing on the same edge.
        done_d  = (core_wrap && (core_state == ST_RUN)) || (done_q && !done_clr);
        if (wr_en) begin
            case (reg_sel)
                REG_CTRL: begin
                    en_d = PWDATA[CTRL_EN_BIT];
                    ie_d = PWDATA[CTRL_IE_BIT];
                end
                REG_PULSE: begin
                    pulse_d = sat_pulse(PWDATA, 32'(MIN_PULSE), 32'(MAX_PULSE));
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pulse_q <= PULSE_W'(NEUTRAL_PULSE);
            done_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        PRDATA = 32'h0;
        if (rd_en) begin
            case (reg_sel)
                REG_CTRL:   PRDATA = {30'h0, ie_q, en_q};
                REG_PULSE:  PRDATA = 32'(pulse_q);
                REG_STATUS: PRDATA = {31'h0, done_q};
                REG_FRAME:  PRDATA = 32'(core_count);
                default:    PRDATA = 32'h0;
            endcase
        end
    end

    servo_pwm_core #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .NEUTRAL_PULSE (NEUTRAL_PULSE)
    ) u_core (
        .clk     (SYSCLK),
        .rst     (SYSRESET),
        .en_i    (en_q),
        .pulse_i (pulse_q),
        .pwm_o   (SERVO_PWM),
        .wrap_o  (core_wrap),
        .count_o (core_count),
        .state_o (core_state)
    );

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign SERVO_INT = done_q && ie_q;

endmodule
